// File: rtl/capi_put_align_sched.sv
// capi_put_align_sched
// Round-robin scheduler that shares one put-data byte aligner between NREQ
// requesters. A granted requester's command (offset, byte length) is latched,
// then its 128-bit beats are forwarded to the aligner. The per-beat valid-byte
// count and end flag come from a remaining-byte register.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   req_v/req_r/req_d   per-requester command {offset[3:0], len}, req 0 in MSBs
//   dat_v/dat_r/dat_d   per-requester 128-bit data beats, req 0 in MSBs
//   a_v/a_r/a_d         alignment offset to the aligner (a_r informational)
//   o_v/o_r/o_d         beat to the aligner
//   o_c, o_e            valid bytes in beat (0 = 16), last beat of stream
//   o_tag               granted requester index
//   busy                stream in progress
//
// state  | meaning
// IDLE   | arbitrating; winner sees req_r, len==0 commands are dropped
// STREAM | forwarding beats of the latched requester until the o_e beat
module capi_put_align_sched #(
  parameter int NREQ = 4,
  parameter int LENW = 13,
  parameter int TAGW = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_v,
  output logic [NREQ-1:0]        req_r,
  input  logic [NREQ*(4+LENW)-1:0] req_d,
  input  logic [NREQ-1:0]        dat_v,
  output logic [NREQ-1:0]        dat_r,
  input  logic [NREQ*128-1:0]    dat_d,
  output logic                   a_v,
  input  logic                   a_r,
  output logic [3:0]             a_d,
  output logic                   o_v,
  input  logic                   o_r,
  output logic [127:0]           o_d,
  output logic [3:0]             o_c,
  output logic                   o_e,
  output logic [TAGW-1:0]        o_tag,
  output logic                   busy
);

  localparam int CW = 4 + LENW;
  localparam logic [LENW-1:0] SIXTEEN = LENW'(16);

  typedef enum logic [0:0] {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [TAGW-1:0]   ptr_q, ptr_d;
  logic [TAGW-1:0]   tag_q, tag_d;
  logic [3:0]        off_q, off_d;
  logic [LENW-1:0]   rem_q, rem_d;

  logic              win_v;
  logic [TAGW-1:0]   win_idx;
  logic [CW-1:0]     win_cmd;
  logic              sel_v;
  logic [127:0]      sel_d;
  logic              last;

  // The aligner samples a_d combinationally, so a_r never gates anything.
  logic unused_a_r;
  assign unused_a_r = a_r;

  function automatic logic [TAGW-1:0] wrap_inc(input logic [TAGW-1:0] t);
    return (t == TAGW'(NREQ-1)) ? '0 : t + 1'b1;
  endfunction

  // Round-robin pick: first pass from the pointer upward, then wrap to 0.
  always_comb begin
    win_v   = 1'b0;
    win_idx = '0;
    win_cmd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_v && req_v[i] && (i >= int'(ptr_q))) begin
        win_v   = 1'b1;
        win_idx = TAGW'(i);
        win_cmd = req_d[(NREQ-1-i)*CW +: CW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_v && req_v[i] && (i < int'(ptr_q))) begin
        win_v   = 1'b1;
        win_idx = TAGW'(i);
        win_cmd = req_d[(NREQ-1-i)*CW +: CW];
      end
    end
  end

  // Data mux for the latched requester.
  always_comb begin
    sel_v = 1'b0;
    sel_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (tag_q == TAGW'(i)) begin
        sel_v = dat_v[i];
        sel_d = dat_d[(NREQ-1-i)*128 +: 128];
      end
    end
  end

  assign last = (rem_q <= SIXTEEN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tag_q   <= '0;
      off_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      off_q   <= off_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    off_d   = off_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (win_v) begin
          tag_d = win_idx;
          off_d = win_cmd[CW-1 -: 4];
          rem_d = win_cmd[LENW-1:0];
          if (win_cmd[LENW-1:0] == '0) ptr_d = wrap_inc(win_idx);
          else                          state_d = STREAM;
        end
      end
      STREAM: begin
        if (sel_v && o_r) begin
          if (last) begin
            state_d = IDLE;
            ptr_d   = wrap_inc(tag_q);
          end else begin
            rem_d = (rem_q > SIXTEEN) ? rem_q - SIXTEEN : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_r = '0;
    dat_r = '0;
    a_v   = 1'b0;
    a_d   = '0;
    o_v   = 1'b0;
    o_d   = '0;
    o_c   = '0;
    o_e   = 1'b0;
    o_tag = '0;
    busy  = 1'b0;
    if (state_q == IDLE) begin
      for (int i = 0; i < NREQ; i++) req_r[i] = win_v && (win_idx == TAGW'(i));
    end else begin
      a_v   = 1'b1;
      a_d   = off_q;
      o_v   = sel_v;
      o_d   = sel_d;
      o_c   = (rem_q < SIXTEEN) ? rem_q[3:0] : 4'd0;
      o_e   = last;
      o_tag = tag_q;
      busy  = 1'b1;
      for (int i = 0; i < NREQ; i++) dat_r[i] = o_r && (tag_q == TAGW'(i));
    end
  end

endmodule

// File: tb/tb_capi_put_align_sched.sv
module tb_capi_put_align_sched;
  localparam int NREQ = 4;
  localparam int LENW = 13;
  localparam int TAGW = 3;
  localparam int CW   = 4 + LENW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_v, req_r, dat_v, dat_r;
  logic [NREQ*CW-1:0]   req_d;
  logic [NREQ*128-1:0]  dat_d;
  logic                 a_v, a_r, o_v, o_r, o_e, busy;
  logic [3:0]           a_d, o_c;
  logic [127:0]         o_d;
  logic [TAGW-1:0]      o_tag;

  capi_put_align_sched #(.NREQ(NREQ), .LENW(LENW), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_v(req_v), .req_r(req_r), .req_d(req_d),
    .dat_v(dat_v), .dat_r(dat_r), .dat_d(dat_d),
    .a_v(a_v), .a_r(a_r), .a_d(a_d),
    .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_c(o_c), .o_e(o_e),
    .o_tag(o_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] off; logic [LENW-1:0] len; } cmd_t;
  typedef struct packed { logic [127:0] d; logic [3:0] c; logic e; logic [3:0] off; } beat_t;

  cmd_t         cq[NREQ][$];
  logic [127:0] dq[NREQ][$];
  beat_t        eq[NREQ][$];
  int           gq[$];

  int chk_cnt = 0, pass_cnt = 0;
  int beats = 0, grants = 0, av_cnt = 0, ov_cnt = 0, rr1_cnt = 0, cur_grant = 0;
  bit rand_or = 1'b0;
  bit hold_pend = 1'b0;
  logic [127:0] hold_d;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_v[i] = (cq[i].size() != 0);
      req_d[(NREQ-1-i)*CW +: CW] = req_v[i] ? cq[i][0] : '0;
      dat_v[i] = (dq[i].size() != 0);
      dat_d[(NREQ-1-i)*128 +: 128] = dat_v[i] ? dq[i][0] : '0;
    end
    o_r = rand_or ? 1'($urandom_range(0, 1)) : 1'b1;
    a_r = 1'($urandom_range(0, 1));
  endtask

  task automatic issue(input int r, input logic [3:0] off, input int len);
    cmd_t c;
    c.off = off;
    c.len = LENW'(len);
    cq[r].push_back(c);
    drive_inputs();
  endtask

  task automatic accept_cmd(input int r);
    cmd_t c;
    int n;
    beat_t b;
    c = cq[r].pop_front();
    check("grant_expected", 128'(gq.size() > 0), 128'(1));
    if (gq.size() > 0) check("grant_order", 128'(r), 128'(gq.pop_front()));
    grants++;
    if (c.len != 0) cur_grant = r;
    n = (int'(c.len) + 15) / 16;
    for (int k = 0; k < n; k++) begin
      b.d   = {$urandom, $urandom, $urandom, $urandom};
      b.c   = (k == n-1) ? c.len[3:0] : 4'd0;
      b.e   = (k == n-1);
      b.off = c.off;
      dq[r].push_back(b.d);
      eq[r].push_back(b);
    end
  endtask

  task automatic step();
    bit acc[NREQ];
    bit dhs[NREQ];
    int t;
    beat_t b;
    @(negedge clk);
    if (a_v) av_cnt++;
    if (o_v) ov_cnt++;
    if (req_r[1]) rr1_cnt++;
    if (hold_pend && o_v) check("o_d_hold", o_d, hold_d);
    hold_pend = o_v && !o_r;
    hold_d    = o_d;
    for (int i = 0; i < NREQ; i++) begin
      acc[i] = req_v[i] && req_r[i];
      dhs[i] = dat_v[i] && dat_r[i];
    end
    if (o_v && o_r) begin
      t = int'(o_tag);
      beats++;
      check("o_tag", 128'(o_tag), 128'(cur_grant));
      check("beat_pending", 128'((t < NREQ) && (eq[t].size() > 0)), 128'(1));
      if ((t < NREQ) && (eq[t].size() > 0)) begin
        b = eq[t].pop_front();
        check("o_d", o_d, b.d);
        check("o_c", 128'(o_c), 128'(b.c));
        check("o_e", 128'(o_e), 128'(b.e));
        check("a_v", 128'(a_v), 128'(1));
        check("a_d", 128'(a_d), 128'(b.off));
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (dhs[i] && dq[i].size() > 0) void'(dq[i].pop_front());
      if (acc[i]) accept_cmd(i);
    end
    drive_inputs();
  endtask

  function automatic bit pending();
    bit p = busy;
    for (int i = 0; i < NREQ; i++)
      if (cq[i].size() != 0 || eq[i].size() != 0 || dq[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic drain(input string tag, input int max_cyc);
    for (int n = 0; n < max_cyc && pending(); n++) step();
    check(tag, 128'(pending()), 128'(0));
  endtask

  int b0, a0, v0, r0;

  initial begin
    reset = 1'b0;
    req_v = '0; req_d = '0; dat_v = '0; dat_d = '0; o_r = 1'b0; a_r = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_o_v", 128'(o_v), 128'(0));
    check("rst_a_v", 128'(a_v), 128'(0));
    check("rst_req_r", 128'(req_r), 128'(0));
    check("rst_dat_r", 128'(dat_r), 128'(0));
    check("rst_o_d", o_d, 128'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    drive_inputs();

    // Simultaneous requests from 0,1,2; requester 0 re-requests mid-run.
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(0);
    issue(0, 4'h1, 32); issue(1, 4'h2, 32); issue(2, 4'h4, 32);
    for (int n = 0; n < 200 && grants < 2; n++) step();
    check("two_grants", 128'(grants >= 2), 128'(1));
    issue(0, 4'h7, 20);
    drain("rr_drain", 400);

    // Single request offset 3, len 40: three beats c = 0,0,8.
    b0 = beats;
    gq.push_back(1);
    issue(1, 4'h3, 40);
    drain("len40_drain", 200);
    check("len40_beats", 128'(beats - b0), 128'(3));
    step();
    check("len40_idle", 128'(busy), 128'(0));

    // Null command from requester 1: pointer moves to 2.
    a0 = av_cnt; v0 = ov_cnt; r0 = rr1_cnt;
    gq.push_back(1);
    issue(1, 4'h9, 0);
    repeat (6) step();
    check("null_rr_pulse", 128'(rr1_cnt - r0), 128'(1));
    check("null_no_a_v", 128'(av_cnt - a0), 128'(0));
    check("null_no_o_v", 128'(ov_cnt - v0), 128'(0));
    check("null_busy", 128'(busy), 128'(0));
    gq.push_back(2); gq.push_back(3); gq.push_back(1);
    issue(1, 4'hA, 16); issue(2, 4'hB, 16); issue(3, 4'hC, 16);
    drain("ptr2_drain", 200);

    // len 1: single beat with o_c = 1.
    b0 = beats;
    gq.push_back(2);
    issue(2, 4'h5, 1);
    drain("len1_drain", 100);
    check("len1_beats", 128'(beats - b0), 128'(1));

    // len 4096, offset F, random back-pressure.
    rand_or = 1'b1;
    b0 = beats;
    gq.push_back(3);
    issue(3, 4'hF, 4096);
    drain("big_drain", 3000);
    check("big_beats", 128'(beats - b0), 128'(256));
    rand_or = 1'b0;

    // Reset during beat 2 of a 5-beat stream.
    b0 = beats;
    gq.push_back(2);
    issue(2, 4'h6, 80);
    for (int n = 0; n < 100 && (beats - b0) < 1; n++) step();
    check("rst_mid_reached", 128'(beats - b0), 128'(1));
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_o_v", 128'(o_v), 128'(0));
    check("rst_mid_a_v", 128'(a_v), 128'(0));
    check("rst_mid_busy", 128'(busy), 128'(0));
    for (int i = 0; i < NREQ; i++) begin
      cq[i].delete(); dq[i].delete(); eq[i].delete();
    end
    gq.delete();
    hold_pend = 1'b0;
    drive_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    gq.push_back(0); gq.push_back(2);
    issue(2, 4'h2, 16); issue(0, 4'h8, 16);
    drain("post_rst_drain", 200);
    check("all_grants_used", 128'(gq.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
